// File: rtl/counter_bench_pkg.sv
// Shared types and defaults for the counter bench sequencer.
// Imported by the sequencer top and its timeout timer.
package counter_bench_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_CLEAR,
        ST_RUN,
        ST_REPORT,
        ST_DONE
    } state_t;

    localparam int DEF_NUM_CNT = 8;
    localparam int DEF_TMO_W   = 32;
    localparam int DEF_SETTLE  = 4;

    localparam int RES_PASS_W  = 1;

    // Packed readout record width: {idx, cycles, pass}
    function automatic int res_rec_w(input int num_cnt, input int tmo_w);
        return $clog2(num_cnt) + tmo_w + RES_PASS_W;
    endfunction

endpackage

// File: rtl/bench_timeout_timer.sv
// Per-run cycle timer with saturating count and limit compare.
// Cleared outside RUN so the first RUN cycle reads zero.
module bench_timeout_timer
    import counter_bench_pkg::*;
#(
    parameter int TMO_W = DEF_TMO_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic [TMO_W-1:0] limit,
    output logic [TMO_W-1:0] count,
    output logic             expired
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (run && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == limit);

endmodule

// File: rtl/counter_bench_sequencer.sv
// Runs each selected counter in turn and reports cycles-to-match.
// One result beat per counter, one done pulse per completed pass.
module counter_bench_sequencer
    import counter_bench_pkg::*;
#(
    parameter  int NUM_CNT = DEF_NUM_CNT,
    parameter  int TMO_W   = DEF_TMO_W,
    parameter  int SETTLE  = DEF_SETTLE,
    localparam int IDX_W   = $clog2(NUM_CNT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [NUM_CNT-1:0] sel_mask,
    input  logic [TMO_W-1:0]   timeout_limit,
    input  logic [NUM_CNT-1:0] cnt_match,
    output logic               cnt_reset,
    output logic [NUM_CNT-1:0] cnt_en,
    output logic               busy,
    output logic               done,
    output logic               res_valid,
    output logic [IDX_W-1:0]   res_idx,
    output logic [TMO_W-1:0]   res_cycles,
    output logic               res_pass,
    output logic [NUM_CNT-1:0] pass_mask
);

    localparam int SET_W = $clog2(SETTLE + 1);

    state_t             state;
    state_t             state_nx;
    logic [IDX_W-1:0]   idx;
    logic [NUM_CNT-1:0] mask_q;
    logic [TMO_W-1:0]   limit_q;
    logic [SET_W-1:0]   settle_cnt;
    logic [TMO_W-1:0]   timer;
    logic               expired;
    logic               hit;
    logic               scan_hit;
    logic [IDX_W-1:0]   scan_idx;

    bench_timeout_timer #(
        .TMO_W (TMO_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != ST_RUN),
        .run     (state == ST_RUN),
        .limit   (limit_q),
        .count   (timer),
        .expired (expired)
    );

    assign hit = cnt_match[idx];

    // Lowest selected index at or above the current one
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = idx;
        for (int i = NUM_CNT - 1; i >= 0; i--) begin
            if (mask_q[i] && (i >= int'(idx))) begin
                scan_hit = 1'b1;
                scan_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_SCAN;
            end
            ST_SCAN: begin
                if (abort)         state_nx = ST_IDLE;
                else if (scan_hit) state_nx = ST_CLEAR;
                else               state_nx = ST_DONE;
            end
            ST_CLEAR: begin
                if (abort)
                    state_nx = ST_IDLE;
                else if (settle_cnt == SET_W'(SETTLE - 1))
                    state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (abort)               state_nx = ST_IDLE;
                else if (hit || expired) state_nx = ST_REPORT;
            end
            ST_REPORT: begin
                if (abort)
                    state_nx = ST_IDLE;
                else if (idx == IDX_W'(NUM_CNT - 1))
                    state_nx = ST_DONE;
                else
                    state_nx = ST_SCAN;
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Pass context: captured selection, limit, and cursor
    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            mask_q     <= '0;
            limit_q    <= '0;
            settle_cnt <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                mask_q  <= sel_mask;
                limit_q <= timeout_limit;
                idx     <= '0;
            end else if (state == ST_SCAN) begin
                idx <= scan_idx;
            end else if (state == ST_REPORT) begin
                idx <= idx + 1'b1;
            end
            if (state == ST_CLEAR) settle_cnt <= settle_cnt + 1'b1;
            else                   settle_cnt <= '0;
        end
    end

    // Outputs are registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reset  <= 1'b1;
            cnt_en     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            res_valid  <= 1'b0;
            res_idx    <= '0;
            res_cycles <= '0;
            res_pass   <= 1'b0;
            pass_mask  <= '0;
        end else begin
            cnt_reset <= (state_nx != ST_RUN);
            busy      <= (state_nx != ST_IDLE);
            done      <= (state_nx == ST_DONE);
            res_valid <= (state_nx == ST_REPORT);
            if (state_nx == ST_RUN)
                cnt_en <= {{(NUM_CNT-1){1'b0}}, 1'b1} << idx;
            else
                cnt_en <= '0;
            if (state == ST_IDLE && start)
                pass_mask <= '0;
            if (state == ST_RUN && state_nx == ST_REPORT) begin
                res_idx        <= idx;
                res_cycles     <= hit ? timer : limit_q;
                res_pass       <= hit;
                pass_mask[idx] <= pass_mask[idx] | hit;
            end
        end
    end

endmodule

// File: tb/tb_counter_bench_sequencer.sv
// Directed bench for counter_bench_sequencer with a counter stub
// that raises match after a programmable number of RUN cycles.
module tb_counter_bench_sequencer;

    localparam int N = 4;
    localparam int W = 32;
    localparam int S = 4;
    localparam int NONE = 100000;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic [N-1:0] sel_mask;
    logic [W-1:0] timeout_limit;
    logic [N-1:0] cnt_match;
    logic [N-1:0] stub;
    logic [N-1:0] noise;
    logic         cnt_reset;
    logic [N-1:0] cnt_en;
    logic         busy;
    logic         done;
    logic         res_valid;
    logic [1:0]   res_idx;
    logic [W-1:0] res_cycles;
    logic         res_pass;
    logic [N-1:0] pass_mask;

    int n_tests = 0;
    int n_fail  = 0;

    int tgt[N];
    int run_cyc[N];

    int r_idx[$];
    int r_cyc[$];
    int r_pass[$];
    int done_cnt = 0;
    int hot_bad  = 0;
    int en_cnt[N];

    int rb;
    int db;
    int eb[N];

    counter_bench_sequencer #(
        .NUM_CNT (N),
        .TMO_W   (W),
        .SETTLE  (S)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .sel_mask      (sel_mask),
        .timeout_limit (timeout_limit),
        .cnt_match     (cnt_match),
        .cnt_reset     (cnt_reset),
        .cnt_en        (cnt_en),
        .busy          (busy),
        .done          (done),
        .res_valid     (res_valid),
        .res_idx       (res_idx),
        .res_cycles    (res_cycles),
        .res_pass      (res_pass),
        .pass_mask     (pass_mask)
    );

    always #5 clk = ~clk;

    // Counter stub: counts its own enabled cycles since reset
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (cnt_reset)      run_cyc[i] <= 0;
            else if (cnt_en[i]) run_cyc[i] <= run_cyc[i] + 1;
        end
    end

    always_comb begin
        stub = '0;
        for (int i = 0; i < N; i++)
            stub[i] = cnt_en[i] && (run_cyc[i] == tgt[i]);
    end

    assign cnt_match = stub | noise;

    always @(negedge clk) begin
        if (res_valid) begin
            r_idx.push_back(int'(res_idx));
            r_cyc.push_back(int'(res_cycles));
            r_pass.push_back(int'(res_pass));
        end
        if (done) done_cnt++;
        for (int i = 0; i < N; i++)
            if (cnt_en[i]) en_cnt[i]++;
        if (!$onehot0(cnt_en)) hot_bad++;
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic snap;
        rb = r_idx.size();
        db = done_cnt;
        for (int i = 0; i < N; i++) eb[i] = en_cnt[i];
    endtask

    task automatic run_pass(input logic [N-1:0] m, input int lim);
        sel_mask      = m;
        timeout_limit = W'(lim);
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 2000) begin
            tick();
            k++;
        end
        check(tag, 64'(done), 64'd1);
        tick();
    endtask

    task automatic rst_vals(input string tag);
        check({tag, " cnt_reset"}, 64'(cnt_reset), 64'd1);
        check({tag, " cnt_en"}, 64'(cnt_en), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " res_valid"}, 64'(res_valid), 64'd0);
        check({tag, " res_idx"}, 64'(res_idx), 64'd0);
        check({tag, " res_cycles"}, 64'(res_cycles), 64'd0);
        check({tag, " res_pass"}, 64'(res_pass), 64'd0);
        check({tag, " pass_mask"}, 64'(pass_mask), 64'd0);
    endtask

    task automatic chk_res(input string tag, input int k,
                           input int ei, input int ec, input int ep);
        if (r_idx.size() > k) begin
            check({tag, " idx"}, 64'(r_idx[k]), 64'(ei));
            check({tag, " cyc"}, 64'(r_cyc[k]), 64'(ec));
            check({tag, " pass"}, 64'(r_pass[k]), 64'(ep));
        end else begin
            check({tag, " present"}, 64'(r_idx.size()), 64'(k + 1));
        end
    endtask

    initial begin
        int k;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        noise = '0;
        sel_mask = '0;
        timeout_limit = '0;
        for (int i = 0; i < N; i++) begin
            tgt[i] = NONE;
            en_cnt[i] = 0;
        end
        repeat (3) tick();
        reset = 1'b0;
        rst_vals("reset");

        // Two selected counters, both match
        snap();
        tgt[0] = 10;
        tgt[2] = 37;
        run_pass(4'b0101, 100);
        check("t1 busy", 64'(busy), 64'd1);
        wait_done("t1 done seen");
        tick();
        check("t1 nres", 64'(r_idx.size() - rb), 64'd2);
        chk_res("t1 r0", rb, 0, 10, 1);
        chk_res("t1 r1", rb + 1, 2, 37, 1);
        check("t1 pass_mask", 64'(pass_mask), 64'b0101);
        check("t1 done cnt", 64'(done_cnt - db), 64'd1);
        check("t1 en1", 64'(en_cnt[1] - eb[1]), 64'd0);
        check("t1 en3", 64'(en_cnt[3] - eb[3]), 64'd0);
        check("t1 en0", 64'(en_cnt[0] - eb[0]), 64'd11);
        check("t1 en2", 64'(en_cnt[2] - eb[2]), 64'd38);
        check("t1 busy end", 64'(busy), 64'd0);

        // Timeout, no match
        snap();
        for (int i = 0; i < N; i++) tgt[i] = NONE;
        run_pass(4'b0010, 5);
        wait_done("t2 done seen");
        tick();
        check("t2 nres", 64'(r_idx.size() - rb), 64'd1);
        chk_res("t2 r0", rb, 1, 5, 0);
        check("t2 en1", 64'(en_cnt[1] - eb[1]), 64'd6);
        check("t2 pass_mask", 64'(pass_mask), 64'd0);

        // Match coincides with timeout; foreign match ignored
        snap();
        tgt[0] = 8;
        noise = 4'b0010;
        run_pass(4'b0001, 8);
        wait_done("t3 done seen");
        noise = '0;
        tick();
        chk_res("t3 r0", rb, 0, 8, 1);
        check("t3 pass_mask", 64'(pass_mask), 64'b0001);

        // Zero limit: fail after one RUN cycle
        snap();
        tgt[0] = NONE;
        run_pass(4'b0001, 0);
        wait_done("t3b done seen");
        tick();
        chk_res("t3b r0", rb, 0, 0, 0);
        check("t3b en0", 64'(en_cnt[0] - eb[0]), 64'd1);

        // Zero limit with match on first RUN cycle
        snap();
        tgt[0] = 0;
        run_pass(4'b0001, 0);
        wait_done("t3c done seen");
        tick();
        chk_res("t3c r0", rb, 0, 0, 1);

        // Empty mask: done two cycles after start
        snap();
        run_pass(4'b0000, 10);
        check("t4 done early", 64'(done), 64'd0);
        tick();
        check("t4 done", 64'(done), 64'd1);
        tick();
        check("t4 done off", 64'(done), 64'd0);
        check("t4 busy off", 64'(busy), 64'd0);
        check("t4 nres", 64'(r_idx.size() - rb), 64'd0);

        // Start while busy is ignored
        snap();
        for (int i = 0; i < N; i++) tgt[i] = 3;
        run_pass(4'b1111, 50);
        repeat (10) tick();
        sel_mask = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t4b done seen");
        repeat (5) tick();
        check("t4b nres", 64'(r_idx.size() - rb), 64'd4);
        chk_res("t4b r3", rb + 3, 3, 3, 1);
        check("t4b done cnt", 64'(done_cnt - db), 64'd1);
        check("t4b pass_mask", 64'(pass_mask), 64'b1111);

        // Abort during RUN of index 2
        snap();
        tgt[0] = 2;
        tgt[1] = 3;
        tgt[2] = NONE;
        tgt[3] = NONE;
        run_pass(4'b1111, 100);
        k = 0;
        while (!cnt_en[2] && k < 200) begin
            tick();
            k++;
        end
        check("t5 reach run2", 64'(cnt_en[2]), 64'd1);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5 cnt_en", 64'(cnt_en), 64'd0);
        check("t5 busy", 64'(busy), 64'd0);
        check("t5 cnt_reset", 64'(cnt_reset), 64'd1);
        repeat (5) tick();
        check("t5 done cnt", 64'(done_cnt - db), 64'd0);
        check("t5 nres", 64'(r_idx.size() - rb), 64'd2);
        check("t5 pass_mask", 64'(pass_mask), 64'b0011);
        check("t5 en3", 64'(en_cnt[3] - eb[3]), 64'd0);

        // Reset during CLEAR
        snap();
        for (int i = 0; i < N; i++) tgt[i] = NONE;
        run_pass(4'b0001, 50);
        tick();
        check("t6 busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rst_vals("t6 clr");

        // Reset during REPORT
        run_pass(4'b0001, 5);
        k = 0;
        while (!res_valid && k < 100) begin
            tick();
            k++;
        end
        check("t6 reach report", 64'(res_valid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rst_vals("t6 rep");
        repeat (5) tick();
        check("t6 done cnt", 64'(done_cnt - db), 64'd0);
        check("t6 idle busy", 64'(busy), 64'd0);

        check("onehot cnt_en", 64'(hot_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
